// File: rtl/celik_lab3_pio_pkg.sv
// Shared constants and helpers for the debounced key PIO.
package celik_lab3_pio_pkg;

  // Avalon-MM word addresses of the register map
  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  // Width of a counter that must hold 0..cycles-1; never narrower than one bit
  function automatic int unsigned debounce_cnt_width(input int unsigned cycles);
    if (cycles <= 32'd2) begin
      return 32'd1;
    end else begin
      return $clog2(cycles);
    end
  endfunction

endpackage

// File: rtl/celik_lab3_debounce_bit.sv
// One key input: two-flop synchronizer, debounce counter and stable level.
// fall is high in the cycle whose closing edge drops stable from 1 to 0.
module celik_lab3_debounce_bit
  import celik_lab3_pio_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter logic        RESET_VAL       = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic in_bit,
  output logic stable,
  output logic fall
);

  localparam int unsigned    CW      = debounce_cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES - 32'd1);

  logic          sync1_r;
  logic          sync2_r;
  logic          stable_r;
  logic [CW-1:0] cnt_r;
  logic          done_s;

  // Decide whether the next edge commits a new stable level, and if it is a press
  always_comb begin
    done_s = 1'b0;
    fall   = 1'b0;
    if ((sync2_r != stable_r) && (cnt_r == CNT_MAX)) begin
      done_s = 1'b1;
      fall   = stable_r;
    end else begin
      done_s = 1'b0;
      fall   = 1'b0;
    end
  end

  // Synchronize the raw input and require DEBOUNCE_CYCLES consecutive differing samples
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1_r  <= RESET_VAL;
      sync2_r  <= RESET_VAL;
      stable_r <= RESET_VAL;
      cnt_r    <= '0;
    end else begin
      sync1_r <= in_bit;
      sync2_r <= sync1_r;
      if (sync2_r == stable_r) begin
        cnt_r <= '0;
      end else if (done_s) begin
        stable_r <= sync2_r;
        cnt_r    <= '0;
      end else begin
        cnt_r <= cnt_r + CW'(1'b1);
      end
    end
  end

  assign stable = stable_r;

endmodule

// File: rtl/celik_lab3_sys_btn_pio.sv
// Avalon-MM key PIO: debounced DATA, IRQMASK and falling-edge EDGECAPTURE with
// a registered level interrupt.
module celik_lab3_sys_btn_pio
  import celik_lab3_pio_pkg::*;
#(
  parameter int unsigned       WIDTH           = 4,
  parameter int unsigned       DEBOUNCE_CYCLES = 50000,
  parameter logic [WIDTH-1:0]  RESET_LEVEL     = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] stable_s;
  logic [WIDTH-1:0] fall_s;
  logic [WIDTH-1:0] clr_s;
  logic             wr_s;
  logic [WIDTH-1:0] irqmask_r;
  logic [WIDTH-1:0] edgecap_r;
  logic             irq_r;
  logic             wdata_unused_s;

  // Bits of writedata above WIDTH are ignored by every register
  assign wdata_unused_s = ^writedata;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    celik_lab3_debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .RESET_VAL       (RESET_LEVEL[i])
    ) u_debounce (
      .clk     (clk),
      .reset_n (reset_n),
      .in_bit  (in_port[i]),
      .stable  (stable_s[i]),
      .fall    (fall_s[i])
    );
  end

  assign wr_s = chipselect & ~write_n;

  // Write-1-to-clear mask for EDGECAPTURE
  always_comb begin
    clr_s = '0;
    if (wr_s && (address == ADDR_EDGECAP)) begin
      clr_s = writedata[WIDTH-1:0];
    end else begin
      clr_s = '0;
    end
  end

  // Register file and interrupt; a capture in the same cycle beats a clear
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      irqmask_r <= '0;
      edgecap_r <= '0;
      irq_r     <= 1'b0;
    end else begin
      if (wr_s && (address == ADDR_IRQMASK)) begin
        irqmask_r <= writedata[WIDTH-1:0];
      end else begin
        irqmask_r <= irqmask_r;
      end
      edgecap_r <= (edgecap_r & ~clr_s) | fall_s;
      irq_r     <= |(edgecap_r & irqmask_r);
    end
  end

  // Zero-wait-state read mux; unmapped addresses and upper bits read as zero
  always_comb begin
    readdata = 32'd0;
    case (address)
      ADDR_DATA:    readdata[WIDTH-1:0] = stable_s;
      ADDR_IRQMASK: readdata[WIDTH-1:0] = irqmask_r;
      ADDR_EDGECAP: readdata[WIDTH-1:0] = edgecap_r;
      default:      readdata = 32'd0;
    endcase
  end

  assign irq = irq_r;

endmodule

// File: tb/tb_celik_lab3_sys_btn_pio.sv
// Scoreboard bench for celik_lab3_sys_btn_pio: directed scenarios plus random traffic.
module tb_celik_lab3_sys_btn_pio;

  localparam int W = 4;
  localparam int D = 4;

  logic          clk;
  logic          reset_n;
  logic [1:0]    address;
  logic          chipselect;
  logic          write_n;
  logic [31:0]   writedata;
  logic [W-1:0]  in_port;
  logic [31:0]   readdata;
  logic          irq;

  celik_lab3_sys_btn_pio #(
    .WIDTH           (W),
    .DEBOUNCE_CYCLES (D),
    .RESET_LEVEL     (4'hF)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .in_port    (in_port),
    .readdata   (readdata),
    .irq        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] data;
    bit          chk_irq;
    logic        irq;
  } rd_exp_t;

  rd_exp_t rd_q[$];
  logic    irq_q[$];
  int      checks = 0;
  int      errors = 0;

  // Reference model: a bit's stable level flips once the last D synchronized
  // samples all disagree with it; the synchronizer delays inputs by two edges.
  logic [W-1:0] m_stable = 4'hF;
  logic [W-1:0] m_mask   = 4'h0;
  logic [W-1:0] m_ecap   = 4'h0;
  logic         m_irq    = 1'b0;
  logic [W-1:0] hist[$];

  initial begin
    logic [W-1:0] fall, nstable, clr, h;
    bit run;
    for (int j = 0; j <= D; j++) hist.push_back(4'hF);
    forever begin
      @(posedge clk);
      if (!reset_n) begin
        m_stable = 4'hF;
        m_mask   = 4'h0;
        m_ecap   = 4'h0;
        m_irq    = 1'b0;
        hist.delete();
        for (int j = 0; j <= D; j++) hist.push_back(4'hF);
      end else begin
        fall    = 4'h0;
        nstable = m_stable;
        for (int b = 0; b < W; b++) begin
          run = 1'b1;
          for (int j = 1; j <= D; j++) begin
            h = hist[j];
            if (h[b] == m_stable[b]) run = 1'b0;
          end
          if (run) begin
            nstable[b] = ~m_stable[b];
            if (m_stable[b]) fall[b] = 1'b1;
          end
        end
        m_irq = |(m_ecap & m_mask);
        clr   = (chipselect && !write_n && address == 2'd3) ? writedata[W-1:0] : 4'h0;
        m_ecap = (m_ecap & ~clr) | fall;
        if (chipselect && !write_n && address == 2'd2) m_mask = writedata[W-1:0];
        m_stable = nstable;
        hist.push_front(in_port);
        void'(hist.pop_back());
      end
      irq_q.push_back(m_irq);
    end
  end

  // Monitor: irq every cycle, readdata whenever a read is presented
  initial begin
    rd_exp_t e;
    logic    ei;
    forever begin
      @(negedge clk);
      if (irq_q.size() > 0) begin
        ei = irq_q.pop_front();
        checks++;
        if (irq !== ei) begin
          errors++;
          $display("FAIL irq_model @%0t: got %b expected %b", $time, irq, ei);
        end
      end
      if (chipselect && write_n) begin
        checks++;
        if (rd_q.size() == 0) begin
          errors++;
          $display("FAIL rd_unexpected @%0t: got read with no expectation queued", $time);
        end else begin
          e = rd_q.pop_front();
          if (readdata !== e.data) begin
            errors++;
            $display("FAIL %s @%0t: readdata got %h expected %h", e.name, $time, readdata, e.data);
          end
          if (e.chk_irq) begin
            checks++;
            if (irq !== e.irq) begin
              errors++;
              $display("FAIL %s_irq @%0t: irq got %b expected %b", e.name, $time, irq, e.irq);
            end
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rdi(input logic [1:0] a, input logic [31:0] exp, input bit ci,
                     input logic ei, input string nm);
    rd_exp_t e;
    chipselect = 1'b1;
    write_n    = 1'b1;
    address    = a;
    e.name = nm; e.data = exp; e.chk_irq = ci; e.irq = ei;
    rd_q.push_back(e);
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string nm);
    rdi(a, exp, 1'b0, 1'b0, nm);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
  endtask

  function automatic logic [31:0] model_read(input logic [1:0] a);
    case (a)
      2'd0:    return {28'd0, m_stable};
      2'd2:    return {28'd0, m_mask};
      2'd3:    return {28'd0, m_ecap};
      default: return 32'd0;
    endcase
  endfunction

  initial begin
    int r;
    reset_n = 1'b0; in_port = 4'hF; chipselect = 1'b0; write_n = 1'b1;
    address = 2'd0; writedata = 32'd0;

    // Reset values
    repeat (3) tick();
    rdi(2'd0, 32'hF, 1'b1, 1'b0, "rst_data"); tick();
    rd(2'd2, 32'h0, "rst_mask"); tick();
    rd(2'd3, 32'h0, "rst_ecap"); tick();
    rd(2'd1, 32'h0, "rst_addr1");
    reset_n = 1'b1;
    tick();

    // Press bit 0: DATA changes on the 6th edge
    in_port = 4'hE;
    for (int i = 1; i <= 6; i++) begin
      tick(); rd(2'd0, (i == 6) ? 32'hE : 32'hF, "press_data");
    end
    tick(); rdi(2'd3, 32'h1, 1'b1, 1'b0, "press_ecap");
    tick(); wr(2'd0, 32'h0);
    tick(); wr(2'd3, 32'h1);
    tick(); in_port = 4'hF;
    for (int i = 1; i <= 6; i++) begin
      tick(); rd(2'd0, (i == 6) ? 32'hF : 32'hE, "release_data");
    end
    tick(); rd(2'd3, 32'h0, "release_ecap");

    // Three-cycle glitch on bit 1 is rejected
    tick(); in_port = 4'hD;
    repeat (3) tick();
    in_port = 4'hF;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (i % 2 == 1) rd(2'd0, 32'hF, "glitch_data");
      else            rd(2'd3, 32'h0, "glitch_ecap");
    end

    // Interrupt on bit 2
    tick(); wr(2'd2, 32'h4);
    tick(); rd(2'd2, 32'h4, "mask_rb"); in_port = 4'hB;
    for (int i = 1; i <= 6; i++) begin
      tick(); rdi(2'd3, (i == 6) ? 32'h4 : 32'h0, 1'b1, 1'b0, "irq_wait");
    end
    tick(); rdi(2'd3, 32'h4, 1'b1, 1'b1, "irq_set");
    tick(); wr(2'd3, 32'h4);
    tick(); rdi(2'd3, 32'h0, 1'b1, 1'b1, "irq_clr_edge");
    tick(); rdi(2'd3, 32'h0, 1'b1, 1'b0, "irq_clr_next");
    tick(); wr(2'd2, 32'h0);
    tick(); in_port = 4'hF;
    for (int i = 1; i <= 6; i++) begin
      tick(); rd(2'd0, (i == 6) ? 32'hF : 32'hB, "irq_release");
    end

    // Set wins over a same-edge clear on bit 3
    tick(); in_port = 4'h7;
    for (int i = 1; i <= 5; i++) tick();
    wr(2'd3, 32'h8);
    tick(); rd(2'd3, 32'h8, "setwin_ecap");
    tick(); rd(2'd0, 32'h7, "setwin_data");
    tick(); wr(2'd3, 32'h8);
    tick(); rd(2'd3, 32'h0, "setwin_clr"); in_port = 4'hF;
    for (int i = 1; i <= 6; i++) tick();
    rd(2'd0, 32'hF, "setwin_release");

    // Reset in the middle of a debounce count
    tick(); in_port = 4'hE;
    repeat (4) tick();
    reset_n = 1'b0; in_port = 4'hF;
    tick(); reset_n = 1'b1; rd(2'd0, 32'hF, "midrst_data");
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (i % 2 == 1) rd(2'd3, 32'h0, "midrst_ecap");
      else            rd(2'd0, 32'hF, "midrst_data2");
    end

    // Random traffic against the model
    for (int n = 0; n < 600; n++) begin
      tick();
      reset_n = 1'b1;
      if ($urandom_range(0, 5) == 0) in_port[$urandom_range(0, W-1)] ^= 1'b1;
      if ($urandom_range(0, 249) == 0) reset_n = 1'b0;
      r = $urandom_range(0, 9);
      if (r <= 5) begin
        address = 2'($urandom_range(0, 3));
        rd(address, model_read(address), "rand_read");
      end else if (r <= 7) begin
        wr(2'($urandom_range(0, 3)), $urandom);
      end
    end
    tick(); reset_n = 1'b1;
    tick();
    @(negedge clk); #1;
    checks++;
    if (rd_q.size() != 0) begin
      errors++;
      $display("FAIL rd_drain: got %0d pending reads expected 0", rd_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
